// File: rtl/pc_next_unit.sv
// Next-PC selection for a MIPS-style fetch stage. It holds a redirect that arrives while
// the pipeline is stalled and replays it once the stall is released.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchOffset,
    input  logic        Jump,
    input  logic [27:0] JumpOffset28,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Flush,
    output logic        PendingRedirect,
    output logic        AlignErr
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        pend_q, pend_d;
    logic        flush_q, flush_d;
    logic        align_q, align_d;

    logic [31:0] pc_plus4;
    logic [31:0] sel_target;
    logic        redirect;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = JumpReg | Jump | BranchTaken;

    // JumpReg outranks Jump, and Jump outranks BranchTaken.
    always_comb begin
        if (JumpReg)
            sel_target = {RegTarget[31:2], 2'b00};
        else if (Jump)
            sel_target = {pc_plus4[31:28], JumpOffset28};
        else
            sel_target = pc_plus4 + BranchOffset;
    end

    // NOTE: every next-state signal gets a default first, so no path through this block infers a latch.
    always_comb begin
        pc_d    = pc_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        flush_d = 1'b0;
        align_d = align_q | (JumpReg & (RegTarget[1:0] != 2'b00));

        if (Stall) begin
            if (redirect) begin
                hold_d = sel_target;
                pend_d = 1'b1;
            end
        end else if (redirect) begin
            pc_d    = sel_target;
            pend_d  = 1'b0;
            flush_d = 1'b1;
        end else if (pend_q) begin
            pc_d    = hold_q;
            pend_d  = 1'b0;
            flush_d = 1'b1;
        end else begin
            pc_d = pc_plus4;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
    // The hold register is reset as well, so a stale target can never be replayed after reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc_q    <= RESET_PC;
            hold_q  <= 32'h0;
            pend_q  <= 1'b0;
            flush_q <= 1'b0;
            align_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
            align_q <= align_d;
        end
    end

    assign PC              = pc_q;
    assign PCPlus4         = pc_plus4;
    assign Flush           = flush_q;
    assign PendingRedirect = pend_q;
    assign AlignErr        = align_q;

endmodule
